bounce_scan_ctrl: RTL

Parametrised one-hot scanner; the next generation of the team's bouncing-bit shift register.
- A single 1 moves across an N-bit register, either ping-ponging between MSB and LSB or rotating in a chosen direction.
- Step rate is programmable through an internal prescaler.
- Arrival at either end gives a single-cycle terminal pulse; completed LSB arrivals are counted with overflow detection.
- Drives LED/strobe scan logic and supplies period ticks to downstream timing blocks.

---
 rtl/bounce_scan_if.sv | 28 ++
 rtl/bounce_scan_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bounce_scan_if.sv
// Control and status bundle for the bouncing one-hot scanner.
// master drives configuration/strobes, slave is the scanner itself.
interface bounce_scan_if #(
    parameter int N       = 8,
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 16
);
    logic               clr_i;
    logic               ena_i;
    logic [1:0]         mode_i;
    logic [PRESC_W-1:0] presc_val_i;
    logic [N-1:0]       q_o;
    logic               dir_o;
    logic               tc_lsb_o;
    logic               tc_msb_o;
    logic [CNT_W-1:0]   period_cnt_o;
    logic               period_ovf_o;

    modport master (
        output clr_i, ena_i, mode_i, presc_val_i,
        input  q_o, dir_o, tc_lsb_o, tc_msb_o, period_cnt_o, period_ovf_o
    );

    modport slave (
        input  clr_i, ena_i, mode_i, presc_val_i,
        output q_o, dir_o, tc_lsb_o, tc_msb_o, period_cnt_o, period_ovf_o
    );
endinterface

// File: rtl/bounce_scan_ctrl.sv
// One-hot scanner: bounces or rotates a single 1 across N bits at a prescaled rate,
// pulses on arrival at either end and counts completed LSB arrivals.
module bounce_scan_ctrl #(
    parameter int N       = 8,
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 16
) (
    input logic         clk,
    input logic         rstna,
    bounce_scan_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_ROT_L  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [N-1:0] Q_RST = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]       q_q, q_d;
    logic               dir_q, dir_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               tc_lsb_q, tc_lsb_d;
    logic               tc_msb_q, tc_msb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               active;
    logic               step;
    mode_e              mode;

    assign mode   = mode_e'(bus.mode_i);
    assign active = bus.ena_i && (mode != MODE_HOLD);
    // >= rather than == so a lowered compare value steps immediately
    assign step   = active && (pcnt_q >= bus.presc_val_i);

    always_comb begin
        q_d      = q_q;
        dir_d    = dir_q;
        pcnt_d   = pcnt_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (active) begin
            pcnt_d = step ? '0 : pcnt_q + PRESC_W'(1);
        end

        if (step) begin
            unique case (mode)
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (q_q[0]) begin
                            dir_d = 1'b0;
                            q_d   = q_q << 1;
                        end else begin
                            q_d   = q_q >> 1;
                        end
                    end else begin
                        if (q_q[N-1]) begin
                            dir_d = 1'b1;
                            q_d   = q_q >> 1;
                        end else begin
                            q_d   = q_q << 1;
                        end
                    end
                end
                MODE_ROT_R: begin
                    dir_d = 1'b1;
                    q_d   = {q_q[0], q_q[N-1:1]};
                end
                MODE_ROT_L: begin
                    dir_d = 1'b0;
                    q_d   = {q_q[N-2:0], q_q[N-1]};
                end
                default: ;
            endcase
        end

        // Pulse only on the step that brings the bit onto an end, never while parked there
        tc_lsb_d = step && !q_q[0] && q_d[0];
        tc_msb_d = step && !q_q[N-1] && q_d[N-1];

        if (tc_lsb_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end

        if (bus.clr_i) begin
            q_d      = Q_RST;
            dir_d    = 1'b1;
            pcnt_d   = '0;
            tc_lsb_d = 1'b0;
            tc_msb_d = 1'b0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstna) begin
        if (!rstna) begin
            q_q      <= Q_RST;
            dir_q    <= 1'b1;
            pcnt_q   <= '0;
            tc_lsb_q <= 1'b0;
            tc_msb_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            dir_q    <= dir_d;
            pcnt_q   <= pcnt_d;
            tc_lsb_q <= tc_lsb_d;
            tc_msb_q <= tc_msb_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.q_o          = q_q;
    assign bus.dir_o        = dir_q;
    assign bus.tc_lsb_o     = tc_lsb_q;
    assign bus.tc_msb_o     = tc_msb_q;
    assign bus.period_cnt_o = cnt_q;
    assign bus.period_ovf_o = ovf_q;

    onehot_a: assert property (@(posedge clk) disable iff (!rstna) $onehot(q_q));

endmodule
